// File: rtl/param_load_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_load_updown_counter
// Brief    : WIDTH-bit parallel-load up/down counter with count enable,
//            optional auto-reload from a latched reload value, registered
//            terminal-count flag and state-decoded busy. Serves as a
//            programmable interval / timeout source.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module param_load_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             select,
    input  logic             enable,
    input  logic             up_down,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             cmpltd,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_cmpltd;
    logic [WIDTH-1:0] r_reload;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_cmpltd_nxt;
    logic [WIDTH-1:0] w_reload_nxt;

    // Terminal value follows the direction input every cycle, so a direction
    // flip mid-count re-targets the terminal and the count never wraps past it.
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_step;

    assign w_term = up_down ? C_ALL_ONES : C_ZERO;
    assign w_step = up_down ? (r_out + C_ONE) : (r_out - C_ONE);

    // State and datapath registers; reset is asynchronous so it clears mid-count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_out    <= C_ZERO;
            r_cmpltd <= 1'b0;
            r_reload <= C_ZERO;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_cmpltd <= w_cmpltd_nxt;
            r_reload <= w_reload_nxt;
        end
    end

    // Next-state / next-count logic; a load overrides everything else.
    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_cmpltd_nxt = r_cmpltd;
        w_reload_nxt = r_reload;

        if (select) begin
            // Load fully defines the count, no prior reset needed.
            w_out_nxt    = in;
            w_reload_nxt = in;
            w_cmpltd_nxt = (in == w_term);
            w_state_nxt  = S_COUNT;
        end else begin
            case (r_state)
                S_COUNT: begin
                    if (enable) begin
                        if (r_out != w_term) begin
                            w_out_nxt    = w_step;
                            w_cmpltd_nxt = (w_step == w_term);
                        end else if (auto_reload) begin
                            // A reload value equal to terminal parks here with
                            // cmpltd high; that is legal and never goes DONE.
                            w_out_nxt    = r_reload;
                            w_cmpltd_nxt = (r_reload == w_term);
                        end else begin
                            w_cmpltd_nxt = 1'b1;
                            w_state_nxt  = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_cmpltd_nxt = 1'b1;
                end
                default: begin
                    // IDLE holds until a load arrives.
                end
            endcase
        end
    end

    assign out    = r_out;
    assign cmpltd = r_cmpltd;
    assign busy   = (r_state == S_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_param_load_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_load_updown_counter
// Brief    : Scoreboard bench for param_load_updown_counter (WIDTH=4).
//            Driver pushes hand-computed expectations, monitor pops/compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_load_updown_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic             select;
    logic             enable;
    logic             up_down;
    logic             auto_reload;
    logic [WIDTH-1:0] out;
    logic             cmpltd;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] e_out;
        logic             e_cmpltd;
        logic             e_busy;
        string            tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    event chk_ev;

    param_load_updown_counter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .select     (select),
        .enable     (enable),
        .up_down    (up_down),
        .auto_reload(auto_reload),
        .out        (out),
        .cmpltd     (cmpltd),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are presented once per edge; sample 1 time unit after it.
    always @(posedge clk) begin
        #1;
        -> chk_ev;
    end

    // Monitor: pop one expectation per presentation and compare.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (out !== e.e_out || cmpltd !== e.e_cmpltd || busy !== e.e_busy) begin
                    errors++;
                    $display("FAIL %s: got out=%0d cmpltd=%0b busy=%0b, want out=%0d cmpltd=%0b busy=%0b",
                             e.tag, out, cmpltd, busy, e.e_out, e.e_cmpltd, e.e_busy);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        repeat (3000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL timeout: stimulus did not complete within 3000 cycles");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic push(input logic [WIDTH-1:0] eo, input logic ec, input logic eb, input string tag);
        exp_t e;
        e.e_out = eo; e.e_cmpltd = ec; e.e_busy = eb; e.tag = tag;
        q.push_back(e);
    endtask

    // One clock edge of stimulus with its expected post-edge outputs.
    task automatic step(input logic s, input logic [WIDTH-1:0] d, input logic en,
                        input logic ud, input logic ar,
                        input logic [WIDTH-1:0] eo, input logic ec, input logic eb,
                        input string tag);
        @(negedge clk);
        select = s; in = d; enable = en; up_down = ud; auto_reload = ar;
        push(eo, ec, eb, tag);
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; select = 1'b0; in = '0; enable = 1'b0; up_down = 1'b0; auto_reload = 1'b0;

        // Reset state
        @(posedge clk);
        #2;
        push(4'd0, 1'b0, 1'b0, "reset_state");
        -> chk_ev;
        @(negedge clk);
        reset = 1'b0;

        // IDLE ignores enable without a load
        step(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, "idle_hold");

        // Load 15, count down to 0, then DONE
        step(1, 4'hF, 1, 0, 0, 4'd15, 0, 1, "load_F");
        for (int k = 14; k >= 0; k--)
            step(0, 4'd0, 1, 0, 0, 4'(k), (k == 0), 1, $sformatf("down_%0d", k));
        step(0, 4'd0, 1, 0, 0, 4'd0, 1, 0, "enter_done");
        step(0, 4'd0, 1, 1, 1, 4'd0, 1, 0, "done_ignores_inputs");

        // Reload without reset while counting down
        step(1, 4'd9, 1, 0, 0, 4'd9, 0, 1, "load_9");
        step(0, 4'd0, 1, 0, 0, 4'd8, 0, 1, "dn_8");
        step(0, 4'd0, 1, 0, 0, 4'd7, 0, 1, "dn_7");
        step(0, 4'd0, 1, 0, 0, 4'd6, 0, 1, "dn_6");
        step(1, 4'hA, 1, 0, 0, 4'd10, 0, 1, "reload_A");
        step(0, 4'd0, 1, 0, 0, 4'd9, 0, 1, "dn_9_after_reload");
        step(0, 4'd0, 1, 0, 0, 4'd8, 0, 1, "dn_8_after_reload");

        // Up count with auto-reload from 12
        step(1, 4'hC, 1, 1, 1, 4'd12, 0, 1, "load_C_up");
        step(0, 4'd0, 1, 1, 1, 4'd13, 0, 1, "up_13");
        step(0, 4'd0, 1, 1, 1, 4'd14, 0, 1, "up_14");
        step(0, 4'd0, 1, 1, 1, 4'd15, 1, 1, "up_15_term");
        step(0, 4'd0, 1, 1, 1, 4'd12, 0, 1, "autoreload_12");
        step(0, 4'd0, 1, 1, 1, 4'd13, 0, 1, "up_13b");
        step(0, 4'd0, 1, 1, 1, 4'd14, 0, 1, "up_14b");
        step(0, 4'd0, 1, 1, 1, 4'd15, 1, 1, "up_15b_term");
        step(0, 4'd0, 1, 1, 1, 4'd12, 0, 1, "autoreload_12b");

        // Enable gating then direction flip to up
        step(1, 4'd5, 0, 0, 0, 4'd5, 0, 1, "load_5_en0");
        step(0, 4'd0, 0, 0, 0, 4'd5, 0, 1, "hold_1");
        step(0, 4'd0, 0, 0, 0, 4'd5, 0, 1, "hold_2");
        step(0, 4'd0, 0, 0, 0, 4'd5, 0, 1, "hold_3");
        step(0, 4'd0, 1, 0, 0, 4'd4, 0, 1, "dn_4");
        for (int k = 5; k <= 15; k++)
            step(0, 4'd0, 1, 1, 0, 4'(k), (k == 15), 1, $sformatf("flip_up_%0d", k));
        step(0, 4'd0, 1, 1, 0, 4'd15, 1, 0, "up_done");

        // Edge loads: value already at terminal
        step(1, 4'd0, 1, 0, 0, 4'd0, 1, 1, "load_0_down");
        step(0, 4'd0, 1, 0, 0, 4'd0, 1, 0, "load_0_done");
        step(1, 4'hF, 0, 1, 0, 4'd15, 1, 1, "load_F_up_term");
        step(1, 4'd0, 1, 0, 1, 4'd0, 1, 1, "load_0_autoreload");
        for (int k = 0; k < 3; k++)
            step(0, 4'd0, 1, 0, 1, 4'd0, 1, 1, $sformatf("park_term_%0d", k));

        // Async reset mid-count at out=9
        step(1, 4'd11, 1, 0, 0, 4'd11, 0, 1, "load_B");
        step(0, 4'd0, 1, 0, 0, 4'd10, 0, 1, "dn_10");
        step(0, 4'd0, 1, 0, 0, 4'd9, 0, 1, "dn_9");
        #3;
        reset = 1'b1;
        #1;
        push(4'd0, 1'b0, 1'b0, "async_reset_midcycle");
        -> chk_ev;
        @(negedge clk);
        push(4'd0, 1'b0, 1'b0, "reset_held_edge");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, "post_reset_idle_1");
        step(0, 4'd0, 1, 1, 0, 4'd0, 0, 0, "post_reset_idle_2");
        step(1, 4'd3, 1, 0, 0, 4'd3, 0, 1, "load_3_after_reset");
        step(0, 4'd0, 1, 0, 0, 4'd2, 0, 1, "dn_2_after_reset");

        // Every pushed expectation must have been consumed by the monitor.
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_load_updown_counter.md
Name: param_load_updown_counter

Overview:
- Parametrised successor to the team's 4-bit T-FF parallel-load down counter.
- Parallel-loadable WIDTH-bit counter with:
  - runtime up/down direction,
  - count enable,
  - optional auto-reload from a latched reload value,
  - a registered terminal-count flag.
- Used as a programmable interval/timeout source.
- Loading does not require a prior reset; load alone fully defines the count value.

Parameters:
- WIDTH, 4, counter and load width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  parallel load value.
- select  input  1  load strobe; 1 = load `in` on this edge.
- enable  input  1  count enable in COUNT state.
- up_down  input  1  1 = count up (terminal = 2^WIDTH-1), 0 = count down (terminal = 0); sampled every edge.
- auto_reload  input  1  1 = on terminal, reload from reload register and keep counting.
- out  output  WIDTH  current count (registered).
- cmpltd  output  1  registered terminal flag.
- busy  output  1  1 while in COUNT state (registered/state-decoded).

Behaviour:
- Reset (async, high): out=0, cmpltd=0, busy=0, reload_reg=0, state=IDLE. Reset takes effect immediately, mid-count included; no counting while reset=1.
- States: IDLE, COUNT, DONE.
- Priority on each rising edge, reset excluded: select > counting.
- Load (select=1, any state):
  - out<=in, reload_reg<=in, state<=COUNT.
  - cmpltd<=(in==terminal(up_down)).
  - Takes effect after that edge (1-cycle latency); enable is ignored on the load edge.
- IDLE: out and cmpltd hold; leaves only via load.
- COUNT, enable=0: out, cmpltd and state hold.
- COUNT, enable=1, out!=terminal:
  - out<=out+1 (up) or out-1 (down), modulo 2^WIDTH arithmetic.
  - cmpltd<=(next out==terminal).
- COUNT, enable=1, out==terminal:
  - auto_reload=1: out<=reload_reg; cmpltd<=(reload_reg==terminal); stay COUNT.
  - auto_reload=0: out holds, cmpltd<=1, state<=DONE.
- DONE:
  - out frozen, cmpltd=1, busy=0.
  - up_down, enable and auto_reload are ignored.
  - Leaves only via load or reset.
- Direction change mid-count: new direction applies from that edge. Terminal is re-evaluated against the new direction, so the count never wraps past a terminal.
- reload_reg==terminal with auto_reload=1: out stays at terminal and cmpltd stays 1 indefinitely. This is legal; the block does not enter DONE.
- Down count from load value L (enable=1, auto_reload=0):
  - out reaches 0 and cmpltd=1 after L edges following the load edge.
  - DONE is entered on the next edge.
- Up count: symmetric, reaching 2^WIDTH-1 after (2^WIDTH-1-L) edges.
- busy = (state==COUNT).

Test Plan (WIDTH=4):
- Reset/load down count:
  - Stimulus: reset pulse; load in=4'hF, up_down=0, enable=1, auto_reload=0.
  - Response: out 15,14,...,0 on successive edges; cmpltd=1 with out=0 on 15th edge after load; busy=0 next edge; out holds 0.
- Reload without reset:
  - Stimulus: while out=6 counting down, select=1 with in=4'hA.
  - Response: out=10, cmpltd=0 next edge; counts down from 10 with no stale bits.
- Up count, auto-reload:
  - Stimulus: load in=4'hC, up_down=1, auto_reload=1, enable=1.
  - Response: out 12,13,14,15 (cmpltd=1 at 15), then 12 with cmpltd=0; repeats; busy stays 1.
- Enable gating and direction flip:
  - Stimulus: load in=5, down; drop enable for 3 cycles; then flip up_down=1.
  - Response: out holds 5 (or current value) while disabled; out then increments toward 15 with no wrap through 0.
- Edge loads:
  - Stimulus: load in=0 with up_down=0.
  - Response: cmpltd=1 immediately after load edge; DONE next enabled edge; out stays 0.
  - Stimulus: auto_reload=1 with in=0, down.
  - Response: out stays 0, cmpltd stays 1, busy stays 1.
- Async reset mid-count:
  - Stimulus: assert reset between clock edges while out=9.
  - Response: out=0, cmpltd=0, busy=0 before the next edge; no counting until a new load.
